// File: rtl/graphics_pkg.sv
// Shared constants and helpers for the display-path blocks.
// Default geometry, colour constants and packed-field slicing.
package graphics_pkg;

  localparam int CW_DEF = 10;
  localparam int CD_DEF = 8;

  localparam logic [3*CD_DEF-1:0] BLACK = '0;

  // Widest packed vector / field the slicing helper handles.
  localparam int FV = 256;
  localparam int FF = 64;

  function automatic logic [FF-1:0] field(
    input logic [FV-1:0] vec,
    input int            idx,
    input int            w
  );
    logic [FV-1:0] mask;
    mask = (FV'(1) << w) - FV'(1);
    return FF'((vec >> (idx * w)) & mask);
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Bundle between timing controller, sprite images and compositor.
// master = upstream driver, slave = compositor.
interface sprite_compositor_if #(
  parameter int N_SPR = 4,
  parameter int CW    = 10,
  parameter int CD    = 8
);

  logic                    pix_en;
  logic [CW-1:0]           xpos;
  logic [CW-1:0]           ypos;
  logic                    de;
  logic                    vblank;
  logic                    upd_valid;
  logic [N_SPR*CW-1:0]     upd_x;
  logic [N_SPR*CW-1:0]     upd_y;
  logic [N_SPR-1:0]        upd_en;
  logic [N_SPR*CW-1:0]     spr_lx;
  logic [N_SPR*CW-1:0]     spr_ly;
  logic [N_SPR*CW-1:0]     spr_w;
  logic [N_SPR*CW-1:0]     spr_h;
  logic [N_SPR*3*CD-1:0]   spr_rgb;
  logic [N_SPR-1:0]        spr_a;
  logic [3*CD-1:0]         bg_rgb;
  logic [3*CD-1:0]         pix_rgb;
  logic                    pix_de;
  logic [N_SPR-1:0]        coll_status;
  logic                    coll_irq;

  modport master (
    output pix_en, xpos, ypos, de, vblank,
    output upd_valid, upd_x, upd_y, upd_en,
    output spr_w, spr_h, spr_rgb, spr_a,
    output bg_rgb,
    input  spr_lx, spr_ly,
    input  pix_rgb, pix_de,
    input  coll_status, coll_irq
  );

  modport slave (
    input  pix_en, xpos, ypos, de, vblank,
    input  upd_valid, upd_x, upd_y, upd_en,
    input  spr_w, spr_h, spr_rgb, spr_a,
    input  bg_rgb,
    output spr_lx, spr_ly,
    output pix_rgb, pix_de,
    output coll_status, coll_irq
  );

endinterface

// File: rtl/sprite_compositor_sprite_hit.sv
// Per-sprite local coordinates and bounding-box hit test.
// End coordinates use one extra bit so edge sprites clip.
module sprite_hit
  import graphics_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic [CW-1:0] xpos,
  input  logic [CW-1:0] ypos,
  input  logic [CW-1:0] act_x,
  input  logic [CW-1:0] act_y,
  input  logic [CW-1:0] w,
  input  logic [CW-1:0] h,
  input  logic          en,
  input  logic          a,
  output logic [CW-1:0] lx,
  output logic [CW-1:0] ly,
  output logic          hit
);

  logic [CW:0] x_end;
  logic [CW:0] y_end;
  logic        in_x;
  logic        in_y;

  assign lx    = xpos - act_x;
  assign ly    = ypos - act_y;

  assign x_end = {1'b0, act_x} + {1'b0, w};
  assign y_end = {1'b0, act_y} + {1'b0, h};

  assign in_x  = (xpos >= act_x) &
                 ({1'b0, xpos} < x_end);
  assign in_y  = (ypos >= act_y) &
                 ({1'b0, ypos} < y_end);

  assign hit   = en & a & in_x & in_y;

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite compositor: frame-synchronous attribute
// update, 2-strobe colour pipeline, per-frame collisions.
module sprite_compositor
  import graphics_pkg::*;
#(
  parameter int N_SPR = 4,
  parameter int CW    = CW_DEF,
  parameter int CD    = CD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sprite_compositor_if.slave bus
);

  localparam int RW = 3 * CD;

  logic [N_SPR*CW-1:0] sh_x_q, sh_x_d;
  logic [N_SPR*CW-1:0] sh_y_q, sh_y_d;
  logic [N_SPR-1:0]    sh_en_q, sh_en_d;
  logic [N_SPR*CW-1:0] act_x_q, act_x_d;
  logic [N_SPR*CW-1:0] act_y_q, act_y_d;
  logic [N_SPR-1:0]    act_en_q, act_en_d;
  logic                vblank_q, vblank_d;
  logic                frame_start;

  logic [N_SPR-1:0]    hit;
  logic [N_SPR*CW-1:0] lx_all;
  logic [N_SPR*CW-1:0] ly_all;

  logic [N_SPR-1:0]    s1_hit_q, s1_hit_d;
  logic [N_SPR*RW-1:0] s1_rgb_q, s1_rgb_d;
  logic [RW-1:0]       s1_bg_q, s1_bg_d;
  logic                s1_de_q, s1_de_d;

  logic [RW-1:0]       pix_rgb_q, pix_rgb_d;
  logic                pix_de_q, pix_de_d;
  logic [RW-1:0]       sel_rgb;

  logic [N_SPR-1:0]    coll_acc_q, coll_acc_d;
  logic [N_SPR-1:0]    coll_status_q, coll_status_d;
  logic                coll_irq_q, coll_irq_d;
  logic [N_SPR-1:0]    coll_add;
  logic                multi;

  assign frame_start = bus.vblank & ~vblank_q;

  for (genvar i = 0; i < N_SPR; i++) begin : g_spr
    sprite_hit #(.CW(CW)) u_hit (
      .xpos  (bus.xpos),
      .ypos  (bus.ypos),
      .act_x (act_x_q[i*CW +: CW]),
      .act_y (act_y_q[i*CW +: CW]),
      .w     (bus.spr_w[i*CW +: CW]),
      .h     (bus.spr_h[i*CW +: CW]),
      .en    (act_en_q[i]),
      .a     (bus.spr_a[i]),
      .lx    (lx_all[i*CW +: CW]),
      .ly    (ly_all[i*CW +: CW]),
      .hit   (hit[i])
    );
  end

  assign bus.spr_lx = lx_all;
  assign bus.spr_ly = ly_all;

  // Lowest index wins: walk from the top down.
  always_comb begin
    sel_rgb = s1_bg_q;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (s1_hit_q[i]) begin
        sel_rgb = RW'(field(FV'(s1_rgb_q), i, RW));
      end
    end
  end

  assign multi    = $countones(s1_hit_q) >= 2;
  assign coll_add = (bus.pix_en & s1_de_q & multi)
                  ? s1_hit_q : '0;

  always_comb begin
    vblank_d = bus.vblank;

    sh_x_d   = bus.upd_valid ? bus.upd_x  : sh_x_q;
    sh_y_d   = bus.upd_valid ? bus.upd_y  : sh_y_q;
    sh_en_d  = bus.upd_valid ? bus.upd_en : sh_en_q;

    // Shadow next-state gives write-through on the boundary.
    act_x_d  = frame_start ? sh_x_d  : act_x_q;
    act_y_d  = frame_start ? sh_y_d  : act_y_q;
    act_en_d = frame_start ? sh_en_d : act_en_q;

    s1_hit_d  = s1_hit_q;
    s1_rgb_d  = s1_rgb_q;
    s1_bg_d   = s1_bg_q;
    s1_de_d   = s1_de_q;
    pix_rgb_d = pix_rgb_q;
    pix_de_d  = pix_de_q;
    if (bus.pix_en) begin
      s1_hit_d  = hit;
      s1_rgb_d  = bus.spr_rgb;
      s1_bg_d   = bus.bg_rgb;
      s1_de_d   = bus.de;
      pix_rgb_d = s1_de_q ? sel_rgb : RW'(BLACK);
      pix_de_d  = s1_de_q;
    end

    coll_status_d = coll_status_q;
    coll_acc_d    = coll_acc_q | coll_add;
    coll_irq_d    = 1'b0;
    if (frame_start) begin
      coll_status_d = coll_acc_q | coll_add;
      coll_acc_d    = '0;
      coll_irq_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblank_q      <= 1'b0;
      sh_x_q        <= '0;
      sh_y_q        <= '0;
      sh_en_q       <= '0;
      act_x_q       <= '0;
      act_y_q       <= '0;
      act_en_q      <= '0;
      s1_hit_q      <= '0;
      s1_rgb_q      <= '0;
      s1_bg_q       <= '0;
      s1_de_q       <= 1'b0;
      pix_rgb_q     <= '0;
      pix_de_q      <= 1'b0;
      coll_acc_q    <= '0;
      coll_status_q <= '0;
      coll_irq_q    <= 1'b0;
    end else begin
      vblank_q      <= vblank_d;
      sh_x_q        <= sh_x_d;
      sh_y_q        <= sh_y_d;
      sh_en_q       <= sh_en_d;
      act_x_q       <= act_x_d;
      act_y_q       <= act_y_d;
      act_en_q      <= act_en_d;
      s1_hit_q      <= s1_hit_d;
      s1_rgb_q      <= s1_rgb_d;
      s1_bg_q       <= s1_bg_d;
      s1_de_q       <= s1_de_d;
      pix_rgb_q     <= pix_rgb_d;
      pix_de_q      <= pix_de_d;
      coll_acc_q    <= coll_acc_d;
      coll_status_q <= coll_status_d;
      coll_irq_q    <= coll_irq_d;
    end
  end

  assign bus.pix_rgb     = pix_rgb_q;
  assign bus.pix_de      = pix_de_q;
  assign bus.coll_status = coll_status_q;
  assign bus.coll_irq    = coll_irq_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed and random checks of sprite_compositor against
// a frame-level reference model.
module tb_sprite_compositor;
  import graphics_pkg::*;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int CD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sprite_compositor_if #(.N_SPR(N), .CW(CW), .CD(CD)) bus ();

  sprite_compositor #(.N_SPR(N), .CW(CW), .CD(CD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int          t_x[N], t_y[N], t_w[N], t_h[N];
  bit          t_en[N], t_a[N];
  logic [23:0] t_rgb[N];

  int m_sx[N], m_sy[N], m_ax[N], m_ay[N];
  bit m_sen[N], m_aen[N];
  bit m_vb;

  typedef struct {
    logic [23:0] rgb;
    bit          de;
    bit [N-1:0]  hit;
  } ent_t;

  ent_t       q[$];
  bit [N-1:0] m_acc, m_status;
  bit         m_irq;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    ent_t z;
    z = '{rgb: '0, de: 1'b0, hit: '0};
    for (int i = 0; i < N; i++) begin
      m_sx[i] = 0; m_sy[i] = 0; m_sen[i] = 0;
      m_ax[i] = 0; m_ay[i] = 0; m_aen[i] = 0;
    end
    m_vb = 0; m_acc = '0; m_status = '0; m_irq = 0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  task automatic drive_attrs();
    for (int i = 0; i < N; i++) begin
      bus.upd_x[i*CW +: CW]     = CW'(t_x[i]);
      bus.upd_y[i*CW +: CW]     = CW'(t_y[i]);
      bus.upd_en[i]             = t_en[i];
      bus.spr_w[i*CW +: CW]     = CW'(t_w[i]);
      bus.spr_h[i*CW +: CW]     = CW'(t_h[i]);
      bus.spr_rgb[i*24 +: 24]   = t_rgb[i];
      bus.spr_a[i]              = t_a[i];
    end
  endtask

  // One clock: check combinational coords, predict, clock, check.
  task automatic cyc();
    logic [N*CW-1:0] elx, ely;
    ent_t       e;
    bit         fs, found;
    bit [N-1:0] add;
    int         x, y;
    #1;
    x = int'(bus.xpos);
    y = int'(bus.ypos);
    for (int i = 0; i < N; i++) begin
      elx[i*CW +: CW] = CW'(x - m_ax[i]);
      ely[i*CW +: CW] = CW'(y - m_ay[i]);
    end
    chk("spr_lx", 64'(bus.spr_lx), 64'(elx));
    chk("spr_ly", 64'(bus.spr_ly), 64'(ely));

    fs = bus.vblank && !m_vb;
    e.de = bus.de;
    e.hit = '0;
    for (int i = 0; i < N; i++) begin
      e.hit[i] = m_aen[i] && t_a[i] &&
                 x >= m_ax[i] && x < m_ax[i] + t_w[i] &&
                 y >= m_ay[i] && y < m_ay[i] + t_h[i];
    end
    e.rgb = bus.bg_rgb;
    found = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && e.hit[i]) begin
        e.rgb = t_rgb[i];
        found = 1;
      end
    end
    if (!e.de) e.rgb = '0;
    add = '0;
    if (bus.pix_en && q[1].de && $countones(q[1].hit) >= 2)
      add = q[1].hit;

    @(posedge clk);
    #1;
    if (bus.pix_en) begin
      q.push_back(e);
      void'(q.pop_front());
    end
    if (fs) begin
      m_status = m_acc | add;
      m_acc    = '0;
      m_irq    = 1;
    end else begin
      m_acc = m_acc | add;
      m_irq = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (bus.upd_valid) begin
        m_sx[i] = t_x[i]; m_sy[i] = t_y[i]; m_sen[i] = t_en[i];
      end
      if (fs) begin
        m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i]; m_aen[i] = m_sen[i];
      end
    end
    m_vb = bus.vblank;

    chk("pix_rgb", 64'(bus.pix_rgb), 64'(q[0].rgb));
    chk("pix_de", 64'(bus.pix_de), 64'(q[0].de));
    chk("coll_status", 64'(bus.coll_status), 64'(m_status));
    chk("coll_irq", 64'(bus.coll_irq), 64'(m_irq));
    @(negedge clk);
  endtask

  task automatic pix(int x, int y, bit d);
    bus.xpos = CW'(x); bus.ypos = CW'(y); bus.de = d;
    bus.pix_en = 1; bus.vblank = 0; bus.upd_valid = 0;
    drive_attrs();
    cyc();
  endtask

  task automatic write_upd();
    bus.pix_en = 0; bus.vblank = 0; bus.upd_valid = 1;
    drive_attrs();
    cyc();
    bus.upd_valid = 0;
  endtask

  task automatic frame();
    bus.pix_en = 0; bus.upd_valid = 0; bus.vblank = 1;
    drive_attrs();
    cyc();
    cyc();
    bus.vblank = 0;
    cyc();
  endtask

  task automatic sprites_off();
    for (int i = 0; i < N; i++) begin
      t_en[i] = 0; t_a[i] = 1; t_w[i] = 16; t_h[i] = 16;
      t_x[i] = 0; t_y[i] = 0;
    end
  endtask

  bit vb;

  initial begin
    bus.pix_en = 0; bus.xpos = '0; bus.ypos = '0;
    bus.de = 0; bus.vblank = 0; bus.upd_valid = 0;
    bus.bg_rgb = 24'h0000FF;
    sprites_off();
    t_rgb[0] = 24'hFF0000; t_rgb[1] = 24'h00FFFF;
    t_rgb[2] = 24'hFFFF00; t_rgb[3] = 24'hFF00FF;
    drive_attrs();
    m_reset();

    #12;
    chk("rst_pix_rgb", 64'(bus.pix_rgb), 64'h0);
    chk("rst_pix_de", 64'(bus.pix_de), 64'h0);
    chk("rst_coll_status", 64'(bus.coll_status), 64'h0);
    chk("rst_coll_irq", 64'(bus.coll_irq), 64'h0);
    @(negedge clk);
    rst = 1;

    // Single sprite
    t_en[0] = 1; t_x[0] = 100; t_y[0] = 50;
    write_upd();
    frame();
    pix(100, 50, 1);
    pix(99, 50, 1);
    chk("single_hit", 64'(bus.pix_rgb), 64'hFF0000);
    chk("single_de", 64'(bus.pix_de), 64'h1);
    pix(116, 50, 1);
    chk("single_left", 64'(bus.pix_rgb), 64'h0000FF);
    pix(0, 0, 1);
    chk("single_right", 64'(bus.pix_rgb), 64'h0000FF);

    // Priority
    t_x[0] = 200; t_y[0] = 200; t_rgb[0] = 24'h00FF00;
    t_en[2] = 1; t_x[2] = 200; t_y[2] = 200;
    write_upd();
    frame();
    pix(205, 205, 1);
    pix(0, 0, 1);
    chk("prio_0", 64'(bus.pix_rgb), 64'h00FF00);
    t_a[0] = 0;
    pix(205, 205, 1);
    pix(0, 0, 1);
    chk("prio_alpha", 64'(bus.pix_rgb), 64'hFFFF00);
    t_a[0] = 1;

    // Deferred update and write-through
    t_x[0] = 300;
    write_upd();
    pix(205, 205, 1);
    pix(305, 205, 1);
    chk("defer_old", 64'(bus.pix_rgb), 64'h00FF00);
    pix(0, 0, 1);
    chk("defer_new_hidden", 64'(bus.pix_rgb), 64'h0000FF);
    frame();
    pix(305, 205, 1);
    pix(0, 0, 1);
    chk("defer_applied", 64'(bus.pix_rgb), 64'h00FF00);
    t_x[0] = 500;
    bus.pix_en = 0; bus.upd_valid = 1; bus.vblank = 1;
    drive_attrs();
    cyc();
    bus.upd_valid = 0;
    cyc();
    bus.vblank = 0;
    cyc();
    pix(505, 205, 1);
    pix(0, 0, 1);
    chk("write_through", 64'(bus.pix_rgb), 64'h00FF00);

    // Collision between sprites 1 and 3
    sprites_off();
    t_en[1] = 1; t_x[1] = 400; t_y[1] = 100;
    t_en[3] = 1; t_x[3] = 410; t_y[3] = 100;
    write_upd();
    frame();
    pix(412, 105, 1);
    pix(0, 0, 1);
    bus.pix_en = 0; bus.vblank = 1;
    cyc();
    chk("coll_status", 64'(bus.coll_status), 64'hA);
    chk("coll_irq_pulse", 64'(bus.coll_irq), 64'h1);
    cyc();
    chk("coll_irq_once", 64'(bus.coll_irq), 64'h0);
    bus.vblank = 0;
    cyc();
    t_x[3] = 700;
    write_upd();
    frame();
    pix(412, 105, 1);
    pix(0, 0, 1);
    bus.pix_en = 0; bus.vblank = 1;
    cyc();
    chk("coll_clear", 64'(bus.coll_status), 64'h0);
    chk("coll_irq_empty", 64'(bus.coll_irq), 64'h1);
    bus.vblank = 0;
    cyc();

    // Right-edge clip
    sprites_off();
    t_rgb[0] = 24'hFF0000;
    t_en[0] = 1; t_x[0] = 1020; t_y[0] = 0;
    write_upd();
    frame();
    pix(1020, 5, 1);
    pix(1023, 5, 1);
    chk("clip_1020", 64'(bus.pix_rgb), 64'hFF0000);
    pix(0, 5, 1);
    chk("clip_1023", 64'(bus.pix_rgb), 64'hFF0000);
    pix(3, 5, 1);
    chk("clip_0", 64'(bus.pix_rgb), 64'h0000FF);
    pix(0, 0, 1);
    chk("clip_3", 64'(bus.pix_rgb), 64'h0000FF);

    // Blanking
    pix(1021, 5, 0);
    pix(0, 0, 1);
    chk("blank_rgb", 64'(bus.pix_rgb), 64'h0);
    chk("blank_de", 64'(bus.pix_de), 64'h0);

    // Random traffic
    for (int i = 0; i < N; i++) t_rgb[i] = 24'($urandom);
    vb = 0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        for (int i = 0; i < N; i++) begin
          t_x[i] = ($urandom_range(0, 4) == 0)
                 ? int'($urandom_range(1005, 1023))
                 : int'($urandom_range(0, 40));
          t_y[i] = int'($urandom_range(0, 40));
          t_w[i] = int'($urandom_range(1, 20));
          t_h[i] = int'($urandom_range(1, 20));
          t_en[i] = ($urandom_range(0, 3) != 0);
        end
      end
      if ($urandom_range(0, 7) == 0)
        t_a[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 29) == 0) vb = ~vb;
      bus.vblank    = vb;
      bus.upd_valid = ($urandom_range(0, 7) == 0);
      bus.pix_en    = ($urandom_range(0, 3) != 0);
      bus.de        = ($urandom_range(0, 4) != 0);
      bus.xpos = ($urandom_range(0, 3) == 0)
               ? CW'($urandom_range(1000, 1023))
               : CW'($urandom_range(0, 63));
      bus.ypos   = CW'($urandom_range(0, 63));
      bus.bg_rgb = 24'($urandom);
      drive_attrs();
      cyc();
    end

    // Asynchronous reset in the middle of a line
    bus.pix_en = 1; bus.de = 1; bus.vblank = 0;
    #2;
    rst = 0;
    #1;
    chk("arst_pix_rgb", 64'(bus.pix_rgb), 64'h0);
    chk("arst_pix_de", 64'(bus.pix_de), 64'h0);
    chk("arst_coll_status", 64'(bus.coll_status), 64'h0);
    chk("arst_coll_irq", 64'(bus.coll_irq), 64'h0);
    m_reset();
    @(negedge clk);
    rst = 1;
    pix(20, 20, 1);
    chk("refill_de", 64'(bus.pix_de), 64'h0);
    pix(21, 20, 1);
    pix(22, 20, 1);
    chk("refilled_de", 64'(bus.pix_de), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
